// File: rtl/dmem_lsu_ctrl.sv
// dmem_lsu_ctrl: RV32 load/store front end for port B of the byte-write BRAM.
// One request is in flight at a time. The BRAM is driven in the accept cycle.
// Loads are aligned and extended one cycle later. Every access, including a
// rejected one, gives exactly one buffered response.
module dmem_lsu_ctrl #(
  parameter int ADDR_WIDTH = 15,
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_we,
  input  logic [2:0]                     req_funct3,
  input  logic [ADDR_WIDTH+1:0]          req_addr,
  input  logic [NUM_COL*COL_WIDTH-1:0]   req_wdata,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [NUM_COL*COL_WIDTH-1:0]   rsp_rdata,
  output logic                           rsp_err,
  output logic                           mem_en,
  output logic [NUM_COL-1:0]             mem_we,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [NUM_COL*COL_WIDTH-1:0]   mem_din,
  input  logic [NUM_COL*COL_WIDTH-1:0]   mem_dout
);

  localparam int DW = NUM_COL * COL_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r;
  logic [1:0]        offset_r;
  logic [2:0]        funct3_r;
  logic              accept_s;
  logic              reqErr_s;
  logic [NUM_COL-1:0] wrMask_s;
  logic [DW-1:0]     wrData_s;

  // Illegal funct3 for the direction, or a halfword/word not on its natural boundary.
  function automatic logic accessErr(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic err;
    case (f3)
      3'b000:  err = 1'b0;
      3'b001:  err = off[0];
      3'b010:  err = |off;
      3'b100:  err = we;
      3'b101:  err = we | off[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  // Pick the addressed byte/half out of the read word and extend it.
  function automatic logic [DW-1:0] loadExtend(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [DW-1:0] word);
    logic [7:0]    lane;
    logic [15:0]   half;
    logic [DW-1:0] res;
    case (off)
      2'd0:    lane = word[7:0];
      2'd1:    lane = word[15:8];
      2'd2:    lane = word[23:16];
      2'd3:    lane = word[31:24];
      default: lane = 8'd0;
    endcase
    half = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{lane[7]}}, lane};
      3'b001:  res = {{16{half[15]}}, half};
      3'b010:  res = word;
      3'b100:  res = {24'd0, lane};
      3'b101:  res = {16'd0, half};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Ready only when idle and out of reset. The reset term keeps the block from accepting while rst is low.
  assign req_ready = (state_r == IDLE) && reset;
  assign accept_s  = req_valid && req_ready;
  assign reqErr_s  = accessErr(req_we, req_funct3, req_addr[1:0]);
  assign mem_addr  = req_addr[ADDR_WIDTH+1:2];
  assign mem_din   = wrData_s;

  // Byte-lane mask and replicated store data for the presented request.
  always_comb begin
    wrMask_s = 4'b0000;
    wrData_s = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        wrMask_s = 4'b0001 << req_addr[1:0];
        wrData_s = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        wrMask_s = 4'b0011 << req_addr[1:0];
        wrData_s = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        wrMask_s = 4'b1111;
        wrData_s = req_wdata;
      end
      default: begin
        wrMask_s = 4'b0000;
        wrData_s = req_wdata;
      end
    endcase
  end

  // BRAM strobes exist only in the accept cycle of a legal request.
  always_comb begin
    mem_en = 1'b0;
    mem_we = 4'b0000;
    if (accept_s && !reqErr_s) begin
      mem_en = 1'b1;
      if (req_we) begin
        mem_we = wrMask_s;
      end else begin
        mem_we = 4'b0000;
      end
    end else begin
      mem_en = 1'b0;
      mem_we = 4'b0000;
    end
  end

  // Request/response sequencing with registered response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      offset_r  <= 2'd0;
      funct3_r  <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (reqErr_s || req_we) begin
              state_r   <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= 32'd0;
              rsp_err   <= reqErr_s;
            end else begin
              state_r  <= RD;
              offset_r <= req_addr[1:0];
              funct3_r <= req_funct3;
            end
          end
        end
        RD: begin
          rsp_rdata <= loadExtend(funct3_r, offset_r, mem_dout);
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state_r   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Self-checking bench for dmem_lsu_ctrl: a byte-addressed reference memory
// predicts each response. A scoreboard queue holds the predictions, and a
// separate monitor compares them.
module tb_dmem_lsu_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [16:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [14:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] memDout;

  dmem_lsu_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(memDout)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sbQ[$];
  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  int          readyMode = 0;
  logic        clearMem;
  logic [31:0] bram [0:63];
  logic [7:0]  refMem [0:255];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Read-first BRAM with byte write enables, standing in for port B.
  always @(posedge clk) begin
    if (clearMem) begin
      for (int i = 0; i < 64; i++) bram[i] <= 32'd0;
      memDout <= 32'd0;
    end else if (mem_en) begin
      memDout <= bram[mem_addr[5:0]];
      for (int l = 0; l < 4; l++)
        if (mem_we[l]) bram[mem_addr[5:0]][8*l +: 8] <= mem_din[8*l +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int accSize(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic isIllegal(input logic we, input logic [2:0] f3);
    if (we) return !(f3 inside {3'b000, 3'b001, 3'b010});
    return !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  endfunction

  // Response-ready driver: random, forced low, or forced high.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (readyMode)
        0:       rsp_ready = ($urandom_range(0, 3) != 0);
        1:       rsp_ready = 1'b0;
        default: rsp_ready = 1'b1;
      endcase
    end
  end

  // Monitor: latency on the first valid cycle, stability while stalled, compare on handshake.
  initial begin
    logic        prevValid;
    logic        holdPending;
    logic [31:0] holdData;
    logic        holdErr;
    exp_t        e;
    prevValid = 1'b0;
    holdPending = 1'b0;
    holdData = 32'd0;
    holdErr = 1'b0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (rsp_valid) begin
          if (sbQ.size() == 0) begin
            check("unexpected_rsp", 32'(rsp_valid), 32'd0);
          end else begin
            if (!prevValid) check("latency", 32'(cyc - sbQ[0].acc), 32'(sbQ[0].lat));
            if (holdPending) begin
              check("hold_rdata", rsp_rdata, holdData);
              check("hold_err", 32'(rsp_err), 32'(holdErr));
            end
            check("req_ready_in_resp", 32'(req_ready), 32'd0);
            if (rsp_ready) begin
              e = sbQ.pop_front();
              check("rsp_rdata", rsp_rdata, e.rdata);
              check("rsp_err", 32'(rsp_err), 32'(e.err));
              holdPending = 1'b0;
            end else begin
              holdPending = 1'b1;
              holdData = rsp_rdata;
              holdErr = rsp_err;
            end
          end
        end else begin
          holdPending = 1'b0;
        end
        prevValid = rsp_valid;
      end else begin
        prevValid = 1'b0;
        holdPending = 1'b0;
      end
    end
  end

  // Present one request; called and returning at posedge+1.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [16:0] a, input logic [31:0] wd,
                       input logic useK, input logic [31:0] kData, input logic kErr);
    int          sz;
    int          ai;
    int          w;
    logic        expErr;
    logic [31:0] expData;
    logic [31:0] expDin;
    logic [3:0]  expWe;
    longint      v;
    longint      one;
    exp_t        e;
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    sz = accSize(f3);
    ai = int'(a);
    expErr = isIllegal(we, f3) || ((ai % sz) != 0);
    expWe = 4'b0000;
    expDin = 32'd0;
    expData = 32'd0;
    if (!expErr && we) begin
      for (int i = 0; i < sz; i++) expWe[(ai % 4) + i] = 1'b1;
      for (int l = 0; l < 4; l++) expDin[8*l +: 8] = wd[8*(l % sz) +: 8];
    end
    check("mem_en", 32'(mem_en), 32'(!expErr));
    check("mem_we", 32'(mem_we), 32'(expWe));
    if (!expErr) check("mem_addr", 32'(mem_addr), 32'(a[16:2]));
    if (!expErr && we) begin
      check("mem_din", mem_din, expDin);
      for (int i = 0; i < sz; i++) refMem[ai + i] = wd[8*i +: 8];
    end
    if (!expErr && !we) begin
      v = 0;
      one = 1;
      for (int i = 0; i < sz; i++) v = v + (longint'(refMem[ai + i]) << (8 * i));
      if (!f3[2] && sz < 4 && v >= (one << (8 * sz - 1))) v = v - (one << (8 * sz));
      expData = v[31:0];
    end
    e.rdata = useK ? kData : expData;
    e.err   = useK ? kErr : expErr;
    e.lat   = (!expErr && !we) ? 2 : 1;
    e.acc   = cyc;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Wait until every predicted response has been consumed.
  task automatic drain();
    int w;
    w = 0;
    while ((sbQ.size() != 0 || rsp_valid) && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("drain_timeout", 32'(sbQ.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [16:0] a;
    logic [31:0] stallData;
    int          k;
    int          w;
    reset = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'd0;
    req_addr = 17'd0;
    req_wdata = 32'd0;
    clearMem = 1'b1;
    for (int i = 0; i < 256; i++) refMem[i] = 8'd0;
    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_mem_en", 32'(mem_en), 32'd0);
    @(posedge clk);
    #1 clearMem = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check("req_ready_after_reset", 32'(req_ready), 32'd1);

    // Directed cases.
    issue(1'b1, 3'b010, 17'h10, 32'hDEADBEEF, 1'b1, 32'd0, 1'b0);
    issue(1'b1, 3'b000, 17'h13, 32'h123456A5, 1'b1, 32'd0, 1'b0);
    issue(1'b0, 3'b000, 17'h13, 32'd0, 1'b1, 32'hFFFFFFA5, 1'b0);
    issue(1'b0, 3'b100, 17'h13, 32'd0, 1'b1, 32'h000000A5, 1'b0);
    issue(1'b1, 3'b010, 17'h10, 32'h80017FFF, 1'b1, 32'd0, 1'b0);
    issue(1'b0, 3'b001, 17'h12, 32'd0, 1'b1, 32'hFFFF8001, 1'b0);
    issue(1'b0, 3'b101, 17'h12, 32'd0, 1'b1, 32'h00008001, 1'b0);
    issue(1'b0, 3'b001, 17'h10, 32'd0, 1'b1, 32'h00007FFF, 1'b0);
    issue(1'b0, 3'b010, 17'h11, 32'd0, 1'b1, 32'd0, 1'b1);
    issue(1'b1, 3'b001, 17'h13, 32'h0000BEEF, 1'b1, 32'd0, 1'b1);
    issue(1'b0, 3'b011, 17'h10, 32'd0, 1'b1, 32'd0, 1'b1);
    issue(1'b1, 3'b100, 17'h10, 32'h11111111, 1'b1, 32'd0, 1'b1);
    drain();

    // Response back-pressure: hold rsp_ready low while a load result waits.
    readyMode = 1;
    issue(1'b0, 3'b010, 17'h10, 32'd0, 1'b1, 32'h80017FFF, 1'b0);
    w = 0;
    @(negedge clk);
    while (!rsp_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("stall_wait_valid", 32'(rsp_valid), 32'd1);
    stallData = rsp_rdata;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        @(negedge clk);
        check("stall_rdata", rsp_rdata, stallData);
      end
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1 readyMode = 2;
    @(negedge clk);
    @(negedge clk);
    check("req_ready_after_hs", 32'(req_ready), 32'd1);
    check("valid_after_hs", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;

    // Reset during RD aborts the load with no response.
    issue(1'b0, 3'b010, 17'h10, 32'd0, 1'b1, 32'h80017FFF, 1'b0);
    reset = 1'b0;
    #1;
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd0);
    sbQ.delete();
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_req_ready_release", 32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_stale", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Random traffic against the byte-level reference memory.
    readyMode = 0;
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        f3 = 3'($urandom_range(0, 7));
      end else if (we) begin
        f3 = 3'($urandom_range(0, 2));
      end else begin
        k = $urandom_range(0, 4);
        f3 = (k > 2) ? 3'(k + 1) : 3'(k);
      end
      a = 17'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a & ~17'(accSize(f3) - 1);
      issue(we, f3, a, $urandom(), 1'b0, 32'd0, 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
